// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle operand fetch / execute / writeback sequencer
// wrapped around an external combinational 16-bit ALU. Owns an 8-entry
// register file, the A/B operand registers (B through a 1-bit shifter),
// and the C result and status registers.

module alu_sequencer #(
  parameter int k = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   opcode,
  input  logic [2:0]   rn,
  input  logic [2:0]   rm,
  input  logic [2:0]   rd,
  input  logic [1:0]   shift,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [k-1:0] wr_data,
  input  logic [2:0]   rd_addr,
  output logic [k-1:0] rd_data,
  output logic [k-1:0] alu_ain,
  output logic [k-1:0] alu_bin,
  output logic [1:0]   alu_op,
  input  logic [k-1:0] alu_out,
  input  logic [2:0]   alu_status,
  output logic [k-1:0] c_q,
  output logic [2:0]   status_q,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE,
    LOADA,
    LOADB,
    EXEC,
    WRITE
  } state_t;

  state_t      state;
  logic [k-1:0] regs [8];
  logic [k-1:0] a_q;
  logic [k-1:0] b_q;
  logic [1:0]   op_q;
  logic [2:0]   rn_q;
  logic [2:0]   rm_q;
  logic [2:0]   rd_q;
  logic [1:0]   shift_q;

  // B-path shifter: none, logical left, logical right, arithmetic right by one
  function automatic logic [k-1:0] shift_b(input logic [1:0] mode, input logic [k-1:0] x);
    logic [k-1:0] r;
    case (mode)
      2'b01:   r = {x[k-2:0], 1'b0};
      2'b10:   r = {1'b0, x[k-1:1]};
      2'b11:   r = {x[k-1], x[k-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Sequencer FSM; busy/done are registered alongside the state so they track it exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      op_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      shift_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      state    <= IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) regs[wr_addr] <= wr_data;
          if (start) begin
            op_q    <= opcode;
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            shift_q <= shift;
            busy    <= 1'b1;
            state   <= LOADA;
          end
        end
        LOADA: begin
          a_q   <= regs[rn_q];
          state <= LOADB;
        end
        LOADB: begin
          b_q   <= shift_b(shift_q, regs[rm_q]);
          state <= EXEC;
        end
        EXEC: begin
          c_q      <= alu_out;
          status_q <= alu_status;
          state    <= WRITE;
        end
        WRITE: begin
          regs[rd_q] <= c_q;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Debug read port and ALU operand drive come straight from registers
  assign rd_data = regs[rd_addr];
  assign alu_ain = a_q;
  assign alu_bin = b_q;
  assign alu_op  = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural
// ALU stub, a register-file reference model and randomized traffic.

module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  opcode;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  shift;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] alu_ain, alu_bin;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic [2:0]  alu_status;
  logic [15:0] c_q;
  logic [2:0]  status_q;
  logic        busy, done;

  alu_sequencer #(.k(16)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .rn(rn), .rm(rm), .rd(rd), .shift(shift),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_status(alu_status),
    .c_q(c_q), .status_q(status_q), .busy(busy), .done(done)
  );

  typedef struct {
    int          due;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] c;
    logic [2:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_regs [8];
  int          next_free;
  int          cyc;
  int          checks;
  int          fails;
  bit          mon_on;

  // ALU behaviour with plain integer arithmetic: {overflow, negative, zero, result}
  function automatic logic [18:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int r, sa, sb, sr;
    logic ovf;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ovf = 1'b0;
    case (op)
      2'd0: begin
        r = (int'(a) + int'(b)) % 65536;
        sr = sa + sb;
        ovf = (sr > 32767) || (sr < -32768);
      end
      2'd1: begin
        r = (int'(a) - int'(b) + 65536) % 65536;
        sr = sa - sb;
        ovf = (sr > 32767) || (sr < -32768);
      end
      2'd2:    r = int'(a & b);
      default: r = 65535 - int'(b);
    endcase
    return {ovf, (r >= 32768), (r == 0), 16'(r)};
  endfunction

  // Shift rules expressed as multiply/divide on the unsigned value
  function automatic logic [15:0] shift_ref(input logic [1:0] m, input logic [15:0] x);
    int v;
    v = int'(x);
    case (m)
      2'd1:    v = (v * 2) % 65536;
      2'd2:    v = v / 2;
      2'd3:    v = v / 2 + ((v >= 32768) ? 32768 : 0);
      default: v = v;
    endcase
    return 16'(v);
  endfunction

  // Combinational ALU stub feeding the sequencer
  always_comb begin
    {alu_status, alu_out} = alu_ref(alu_op, alu_ain, alu_bin);
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge counter: after edge n the counter reads n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one edge worth of inputs at the negedge and advance the reference model
  task automatic applyStimulus(input bit rst, input bit st, input logic [1:0] op,
                               input logic [2:0] rn_i, input logic [2:0] rm_i, input logic [2:0] rd_i,
                               input logic [1:0] sh, input bit we, input logic [2:0] wa,
                               input logic [15:0] wd);
    int e;
    exp_t x;
    logic [18:0] r;
    @(negedge clk);
    reset = rst; start = st; opcode = op; rn = rn_i; rm = rm_i; rd = rd_i;
    shift = sh; wr_en = we; wr_addr = wa; wr_data = wd;
    e = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;
      sb_q.delete();
      next_free = e + 1;
    end else if (e >= next_free) begin
      if (we) model_regs[wa] = wd;
      if (st) begin
        x.a  = model_regs[rn_i];
        x.b  = shift_ref(sh, model_regs[rm_i]);
        x.op = op;
        r    = alu_ref(op, x.a, x.b);
        x.c  = r[15:0];
        x.st = r[18:16];
        x.due = e + 4;
        model_regs[rd_i] = x.c;
        sb_q.push_back(x);
        next_free = e + 5;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 0, 3'd0, 16'h0);
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    applyStimulus(0, 0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1, a, d);
  endtask

  task automatic op(input logic [1:0] o, input logic [2:0] n, input logic [2:0] m,
                    input logic [2:0] d, input logic [1:0] s);
    applyStimulus(0, 1, o, n, m, d, s, 0, 3'd0, 16'h0);
  endtask

  // Compare every register against the model through the debug port
  task automatic checkRegs(input string tag);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      checkOutput($sformatf("%s_R%0d", tag, i), {16'h0, rd_data}, {16'h0, model_regs[i]});
    end
  endtask

  // Monitor: checks busy/done every cycle and pops the scoreboard on each completion
  initial begin
    bit eb, ed;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        eb = (sb_q.size() > 0) && (cyc >= sb_q[0].due - 4) && (cyc < sb_q[0].due);
        ed = (sb_q.size() > 0) && (cyc == sb_q[0].due);
        checkOutput("busy", {31'h0, busy}, {31'h0, eb});
        checkOutput("done", {31'h0, done}, {31'h0, ed});
        if (sb_q.size() > 0 && cyc == sb_q[0].due - 2) begin
          checkOutput("alu_ain", {16'h0, alu_ain}, {16'h0, sb_q[0].a});
          checkOutput("alu_bin", {16'h0, alu_bin}, {16'h0, sb_q[0].b});
          checkOutput("alu_op", {30'h0, alu_op}, {30'h0, sb_q[0].op});
        end
        if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
          x = sb_q.pop_front();
          checkOutput("c_q", {16'h0, c_q}, {16'h0, x.c});
          checkOutput("status_q", {29'h0, status_q}, {29'h0, x.st});
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; fails = 0; cyc = 0; next_free = 0; mon_on = 0;
    reset = 1; start = 0; opcode = 0; rn = 0; rm = 0; rd = 0; shift = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;

    applyStimulus(1, 0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 0, 3'd0, 16'h0);
    applyStimulus(1, 0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 0, 3'd0, 16'h0);
    mon_on = 1;
    idle(1);
    checkRegs("reset");

    // Basic add: R3 = 5 + 3
    write(3'd1, 16'd5);
    write(3'd2, 16'd3);
    op(2'd0, 3'd1, 3'd2, 3'd3, 2'd0);
    idle(6);
    checkRegs("add");
    checkOutput("add_R3_const", {16'h0, model_regs[3]}, 32'd8);

    // Subtract to zero and to negative
    write(3'd1, 16'd3);
    op(2'd1, 3'd1, 3'd2, 3'd4, 2'd0);
    idle(5);
    write(3'd1, 16'd2);
    op(2'd1, 3'd1, 3'd2, 3'd5, 2'd0);
    idle(6);
    checkRegs("sub");

    // Shift modes through not-B
    write(3'd2, 16'h8001);
    for (int s = 1; s < 4; s++) begin
      op(2'd3, 3'd0, 3'd2, 3'd6, 2'(s));
      idle(5);
    end
    idle(1);
    checkRegs("shift");

    // start while busy and wr_en during EXEC are both ignored
    op(2'd0, 3'd1, 3'd2, 3'd7, 2'd0);
    idle(1);
    op(2'd2, 3'd5, 3'd5, 3'd0, 2'd1);
    applyStimulus(0, 0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1, 3'd4, 16'hDEAD);
    idle(6);
    checkRegs("ignore");

    // Reset during EXEC aborts; outputs clear
    op(2'd0, 3'd1, 3'd1, 3'd2, 2'd0);
    idle(2);
    applyStimulus(1, 0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 0, 3'd0, 16'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_c_q", {16'h0, c_q}, 32'h0);
    checkOutput("rst_status", {29'h0, status_q}, 32'h0);
    checkOutput("rst_ain", {16'h0, alu_ain}, 32'h0);
    checkOutput("rst_bin", {16'h0, alu_bin}, 32'h0);
    checkOutput("rst_op", {30'h0, alu_op}, 32'h0);
    idle(1);
    checkRegs("abort");

    // Back-to-back: second start in the done cycle
    write(3'd1, 16'h1234);
    write(3'd2, 16'h0F0F);
    op(2'd0, 3'd1, 3'd2, 3'd3, 2'd0);
    idle(4);
    op(2'd2, 3'd3, 3'd1, 3'd4, 2'd2);
    idle(6);
    checkRegs("b2b");

    // Same-cycle write and start with fully aliased registers
    applyStimulus(0, 1, 2'd0, 3'd1, 3'd1, 3'd1, 2'd0, 1, 3'd1, 16'd7);
    idle(6);
    checkRegs("alias");
    checkOutput("alias_R1_const", {16'h0, model_regs[1]}, 32'd14);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0,
                    2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                    $urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom));
    end
    idle(7);
    checkOutput("drain", sb_q.size(), 32'd0);
    checkRegs("random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
